switch_conditioner: RTL and testbench
=====================================

Name: switch_conditioner

Overview:
- Conditions the three raw slide/push inputs (s0, s1, s2) before they reach the counter stage.
- Per channel: 2-FF synchroniser, counter-based debounce and edge detection, and optional hold-to-auto-repeat.
- Produces single-cycle step pulses and clean levels for the counter.
- Runs in the slow display clock domain (clk_khz); all outputs are registered.

Parameters:
- DEBOUNCE_CYCLES, 20, consecutive synchronised cycles a new value must persist before the debounced level changes (>=1)
- HOLD_CYCLES, 500, cycles a press must be held before the first auto-repeat step (>=2)
- REPEAT_CYCLES, 100, cycles between subsequent auto-repeat steps (>=1)
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = sw_step equals sw_press

Ports:
- clk  input  1  clock, rising-edge active (clk_khz domain)
- rst_n  input  1  asynchronous active-low reset
- sw_in  input  3  raw switch inputs {s2,s1,s0}, asynchronous to clk, active-high
- sw_level  output  3  debounced level per channel
- sw_press  output  3  one-cycle pulse on debounced 0->1
- sw_release  output  3  one-cycle pulse on debounced 1->0
- sw_step  output  3  one-cycle pulse on press and on each auto-repeat tick

Behaviour:
- Reset (rst_n=0, asynchronous): sync FFs, debounce counters, hold/repeat counters and all outputs go to 0; FSM goes to IDLE. Deassertion is taken synchronously at the next clk edge.
- Channels are fully independent; simultaneous activity on several channels is processed in parallel with no priority.
- Synchroniser: meta <= sw_in; sync <= meta.
- Debounce counter, width clog2(DEBOUNCE_CYCLES+1):
  - sync == sw_level: counter <= 0.
  - sync != sw_level and counter == DEBOUNCE_CYCLES-1: sw_level <= sync, counter <= 0.
  - otherwise: counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES clears the counter and never changes sw_level.
- Latency: input stable from before edge k -> sw_level changes on edge k+1+DEBOUNCE_CYCLES.
- Pulses:
  - sw_press asserts on the same edge sw_level goes 1, for exactly one cycle.
  - sw_release likewise on the edge sw_level goes 0.
- Per-channel FSM, states IDLE, HELD, REPEAT:
  - IDLE: on debounced press -> HELD; hold counter <= 0; sw_step pulses this cycle (with sw_press).
  - HELD: hold counter increments each cycle.
    - On the edge where it would reach HOLD_CYCLES (i.e. press edge P + HOLD_CYCLES) and REPEAT_EN=1: sw_step pulses, counter <= 0, -> REPEAT.
    - If REPEAT_EN=0, stays in HELD; the counter saturates at HOLD_CYCLES.
  - REPEAT: counter increments; at REPEAT_CYCLES it pulses sw_step and clears to 0. Step edges are P+HOLD_CYCLES+n*REPEAT_CYCLES.
  - Any state: debounced release -> IDLE, sw_release pulses, no sw_step that cycle, counters cleared.
- Release and a scheduled repeat tick on the same edge: release wins, no step.
- Hold/repeat counter width: clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1); it never wraps.
- Reset mid-press: all state clears. If the input is still high after reset, a fresh press (and sw_step) is generated DEBOUNCE_CYCLES+2 edges after rst_n deassertion.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, REPEAT_EN=1):
- Clean press: sw_in[0] 0->1 before edge 10, held -> sw_level[0]=1 from edge 15; sw_press[0] and sw_step[0] high only in the cycle after edge 15; channels 1 and 2 stay 0.
- Bounce rejection: sw_in[1] pulses high for 3 cycles, low 2, high 3, then low -> sw_level[1], sw_press[1] and sw_step[1] never assert.
- Auto-repeat: sw_in[2] held 40 cycles, press at edge P -> sw_step[2] at P, P+10, P+13, P+16, ...; release -> exactly one sw_release[2], no step on the release edge, FSM back to IDLE.
- Simultaneous channels: sw_in=3'b111 asserted together -> all three sw_press bits pulse on the same edge. Releasing ch0 only -> sw_release=3'b001 while ch1/ch2 repeat steps continue unchanged.
- Async reset mid-repeat: rst_n low between edges while in REPEAT -> all outputs 0 immediately. Input still high after rst_n=1 -> new sw_press 6 edges after deassertion.
- REPEAT_EN=0: hold sw_in[0] 50 cycles -> exactly one sw_step[0] (coincident with sw_press[0]); sw_level[0] stays 1 throughout.

Source files
------------

// File: rtl/switch_conditioner.sv
// Three-channel switch front end: 2-FF synchroniser, counter debounce, edge pulses
// and a hold-to-auto-repeat step generator per channel. All outputs registered.
//
// state  | meaning
// IDLE   | debounced level low, waiting for a press
// HELD   | pressed, counting towards the first auto-repeat step
// REPEAT | auto-repeating, stepping every REPEAT_CYCLES
module switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int HOLD_CYCLES     = 500,
  parameter int REPEAT_CYCLES   = 100,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw_in,
  output logic [2:0] sw_level,
  output logic [2:0] sw_press,
  output logic [2:0] sw_release,
  output logic [2:0] sw_step
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic          r_meta, r_sync, r_level;
    logic          r_press, r_release, r_step;
    logic [DW-1:0] r_dcnt;
    logic [HW-1:0] r_hcnt;
    state_t        r_state;
    logic          w_flip, w_press, w_release;

    // The debounced level flips on the edge the counter would complete its run
    assign w_flip    = (r_sync != r_level) && (r_dcnt == DEB_LAST);
    assign w_press   = w_flip & r_sync;
    assign w_release = w_flip & ~r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_meta    <= 1'b0;
        r_sync    <= 1'b0;
        r_level   <= 1'b0;
        r_dcnt    <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_meta    <= sw_in[g];
        r_sync    <= r_meta;
        r_press   <= w_press;
        r_release <= w_release;
        if (r_sync == r_level) begin
          r_dcnt <= '0;
        end else if (w_flip) begin
          r_level <= r_sync;
          r_dcnt  <= '0;
        end else begin
          r_dcnt <= r_dcnt + DW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= IDLE;
        r_hcnt  <= '0;
        r_step  <= 1'b0;
      end else begin
        r_step <= 1'b0;
        // Release beats any repeat tick falling on the same edge
        if (w_release) begin
          r_state <= IDLE;
          r_hcnt  <= '0;
        end else begin
          case (r_state)
            IDLE: begin
              if (w_press) begin
                r_state <= HELD;
                r_hcnt  <= '0;
                r_step  <= 1'b1;
              end
            end
            HELD: begin
              if (REPEAT_EN && (r_hcnt == HOLD_LAST)) begin
                r_state <= REPEAT;
                r_hcnt  <= '0;
                r_step  <= 1'b1;
              end else if (r_hcnt != HOLD_SAT) begin
                r_hcnt <= r_hcnt + HW'(1);
              end
            end
            REPEAT: begin
              if (r_hcnt == REP_LAST) begin
                r_hcnt <= '0;
                r_step <= 1'b1;
              end else begin
                r_hcnt <= r_hcnt + HW'(1);
              end
            end
            default: begin
              r_state <= IDLE;
              r_hcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign sw_level[g]   = r_level;
    assign sw_press[g]   = r_press;
    assign sw_release[g] = r_release;
    assign sw_step[g]    = r_step;
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: per-cycle scoreboard against a timing model,
// a table-driven clean-press check and hand sequences for the multi-cycle corners.
module tb_switch_conditioner;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw_in, sw_level, sw_press, sw_release, sw_step;
  logic [2:0] sw_nr, nr_level, nr_press, nr_release, nr_step;

  int n_checks = 0;
  int n_errors = 0;
  int edge_no  = 0;

  switch_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in),
    .sw_level(sw_level), .sw_press(sw_press), .sw_release(sw_release), .sw_step(sw_step));

  switch_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_nr),
    .sw_level(nr_level), .sw_press(nr_press), .sw_release(nr_release), .sw_step(nr_step));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_no++;

  // Timing model: step when age since press is 0, or H + n*R; release suppresses step.
  logic [2:0]  m_meta = '0, m_sync = '0, m_lvl = '0;
  int          m_dcnt [3];
  int          m_age  [3];
  logic [11:0] exp_q [$];

  always @(posedge clk) begin
    logic [2:0] p, r, s;
    p = '0; r = '0; s = '0;
    if (!rst_n) begin
      m_meta = '0; m_sync = '0; m_lvl = '0;
      for (int c = 0; c < 3; c++) begin m_dcnt[c] = 0; m_age[c] = 0; end
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (m_sync[c] == m_lvl[c]) m_dcnt[c] = 0;
        else if (m_dcnt[c] == D - 1) begin
          m_lvl[c]  = m_sync[c];
          m_dcnt[c] = 0;
          if (m_lvl[c]) p[c] = 1'b1; else r[c] = 1'b1;
        end else m_dcnt[c]++;
        if (p[c]) begin
          m_age[c] = 0;
          s[c]     = 1'b1;
        end else if (m_lvl[c]) begin
          m_age[c]++;
          s[c] = (m_age[c] >= H) && (((m_age[c] - H) % R) == 0);
        end
      end
      m_sync = m_meta;
      m_meta = sw_in;
    end
    exp_q.push_back({m_lvl, p, r, s});
  end

  always @(negedge clk) begin
    logic [11:0] e, got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {sw_level, sw_press, sw_release, sw_step};
      n_checks++;
      if (got !== e) begin
        n_errors++;
        $display("FAIL scoreboard edge %0d: got lvl/prs/rel/stp %b %b %b %b expected %b %b %b %b",
                 edge_no, got[11:9], got[8:6], got[5:3], got[2:0], e[11:9], e[8:6], e[5:3], e[2:0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] in;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
    logic [2:0] stp;
  } vec_t;

  vec_t tbl [16];
  int   step_edges [$];
  int   p_edge, rel_edge, rel_cnt;
  logic seen_p, seen_r, bad;
  logic [19:0] bounce;
  int   nr_steps, nr_presses, nr_odd, nr_lvl;

  initial begin
    // Entry j: input driven at this negedge, outputs expected after posedge k+j.
    tbl[0]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[2]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[3]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[4]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[5]  = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b001};
    tbl[6]  = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[7]  = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[8]  = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[9]  = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[10] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[11] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[12] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[13] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
    tbl[14] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[15] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

    rst_n = 1'b0; sw_in = '0; sw_nr = '0;
    sw_in = 3'b111;
    wait_neg(2);
    check("reset outputs", {sw_level, sw_press, sw_release, sw_step}, 12'h000);
    check("reset outputs nr", {nr_level, nr_press, nr_release, nr_step}, 12'h000);
    sw_in = '0;
    wait_neg(1);
    rst_n = 1'b1;
    wait_neg(4);

    // Clean press and release on channel 0
    for (int j = 0; j < 16; j++) begin
      sw_in = tbl[j].in;
      wait_neg(1);
      check($sformatf("clean press vec %0d", j), {sw_level, sw_press, sw_release, sw_step},
            {tbl[j].lvl, tbl[j].prs, tbl[j].rel, tbl[j].stp});
    end
    wait_neg(4);

    // Bounce on channel 1: 3 high, 2 low, 3 high, then low
    bounce = 20'b0000_0000_0000_1110_0111;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sw_in = {1'b0, bounce[i], 1'b0};
      wait_neg(1);
      bad |= sw_level[1] | sw_press[1] | sw_step[1];
    end
    check("bounce rejected", bad, 1'b0);

    // Auto-repeat on channel 2: held 40 cycles; release collides with tick P+40
    p_edge = -1; rel_edge = -1; rel_cnt = 0;
    step_edges.delete();
    for (int i = 0; i < 55; i++) begin
      sw_in = (i < 40) ? 3'b100 : 3'b000;
      wait_neg(1);
      if (sw_step[2]) step_edges.push_back(edge_no);
      if (sw_press[2]) p_edge = edge_no;
      if (sw_release[2]) begin rel_edge = edge_no; rel_cnt++; end
    end
    check("repeat step count", step_edges.size(), 11);
    for (int n = 0; n < step_edges.size() && n < 11; n++)
      check($sformatf("repeat step %0d edge", n), step_edges[n],
            (n == 0) ? p_edge : p_edge + H + R * (n - 1));
    check("repeat release count", rel_cnt, 1);
    check("repeat release edge", rel_edge, p_edge + 40);
    wait_neg(4);

    // Simultaneous channels, then release ch0 only
    seen_p = 1'b0; seen_r = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sw_in = (i < 20) ? 3'b111 : 3'b110;
      wait_neg(1);
      if (!seen_p && sw_press != 3'b000) begin
        check("simul press", sw_press, 3'b111);
        seen_p = 1'b1;
      end
      if (!seen_r && sw_release != 3'b000) begin
        check("simul release ch0", sw_release, 3'b001);
        seen_r = 1'b1;
      end
    end
    check("simul press seen", seen_p, 1'b1);
    check("simul release seen", seen_r, 1'b1);

    // Asynchronous reset while ch1/ch2 are in REPEAT
    check("pre-reset level", sw_level, 3'b110);
    #2 rst_n = 1'b0;
    #1 check("async reset clears", {sw_level, sw_press, sw_release, sw_step}, 12'h000);
    wait_neg(2);
    rst_n = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      wait_neg(1);
      if (j == 5) check("post-reset press early", sw_press, 3'b000);
      if (j == 6) begin
        check("post-reset press", sw_press, 3'b110);
        check("post-reset step", sw_step, 3'b110);
      end
    end
    sw_in = '0;
    wait_neg(20);

    // REPEAT_EN=0 instance: one step, coincident with press
    nr_steps = 0; nr_presses = 0; nr_odd = 0; nr_lvl = 0;
    for (int i = 0; i < 60; i++) begin
      sw_nr = (i < 50) ? 3'b001 : 3'b000;
      wait_neg(1);
      if (i < 50 && nr_level[0]) nr_lvl++;
      if (nr_step[0]) nr_steps++;
      if (nr_press[0]) nr_presses++;
      if (nr_step[0] != nr_press[0]) nr_odd++;
    end
    check("no-repeat step count", nr_steps, 1);
    check("no-repeat press count", nr_presses, 1);
    check("no-repeat step with press", nr_odd, 0);
    check("no-repeat level held", nr_lvl, 45);

    wait_neg(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
